// File: rtl/snake_pkg.sv
// Shared snake definitions: direction encodings and the opposite-direction helper.
package snake_pkg;

    localparam int DIR_W = 3;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_NONE  = 3'b000;
    localparam dir_t DIR_UP    = 3'b001;
    localparam dir_t DIR_DOWN  = 3'b010;
    localparam dir_t DIR_LEFT  = 3'b011;
    localparam dir_t DIR_RIGHT = 3'b100;
    localparam dir_t DIR_RESET = 3'b111;

    // Opposite heading; anything that is not a real heading maps to DIR_NONE.
    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// Button conditioner: multi-flop synchroniser followed by a stable-level debouncer.
// `state` is the debounced pressed level, `press` pulses for one cycle on released->pressed.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic state,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CNT_W-1:0]       cnt;
    logic                   level;

    // Synchroniser chain, reset to the idle (released) input level so no false press appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_p0 <= {SYNC_STAGES{ACTIVE_LOW}};
        else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
    end

    assign level = ACTIVE_LOW ? ~sync_p0[SYNC_STAGES-1] : sync_p0[SYNC_STAGES-1];

    // Count consecutive cycles of a level differing from the accepted state; any match restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (level == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= level;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_dir_queue_ctrl.sv
// Snake direction controller: debounced buttons feed a small direction FIFO drained by game ticks.
// Optional build macro SNAKE_REVERSE_FILTER_EN drops presses opposite to the reference heading.
module snake_dir_queue_ctrl
    import snake_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter int   SYNC_STAGES     = 2,
    parameter int   QUEUE_DEPTH     = 4,
    parameter dir_t DIR_START       = 3'b100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   btn_dir_n,
    input  logic                         btn_restart,
    input  logic                         tick,
    output logic [DIR_W-1:0]             direction,
    output logic                         game_reset,
    output logic [$clog2(QUEUE_DEPTH):0] q_level,
    output logic                         overflow
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int LW = AW + 1;

    logic [3:0]  dir_press;
    logic [3:0]  dir_held_unused;   // only press edges drive the queue
    logic        rst_db;
    logic        rst_press_unused;

    dir_t        mem [QUEUE_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_prev, level;
    dir_t        dir_q, ev_dir, tail, ref_dir;
    logic        empty, full, rev, ev_ok, pop, push, drop_full;

    for (genvar i = 0; i < 4; i++) begin : g_dir_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (1'b1)
        ) u_dir (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_dir_n[i]),
            .state(dir_held_unused[i]),
            .press(dir_press[i])
        );
    end

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (1'b0)
    ) u_restart (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_restart),
        .state(rst_db),
        .press(rst_press_unused)
    );

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == LW'(QUEUE_DEPTH));
    assign wr_prev = wr_ptr - 1'b1;
    assign tail    = mem[wr_prev[AW-1:0]];
    assign ref_dir = empty ? dir_q : tail;

    // Pick the single winning press event: UP beats DOWN beats LEFT beats RIGHT.
    always_comb begin
        ev_dir = DIR_NONE;
        if      (dir_press[0]) ev_dir = DIR_UP;
        else if (dir_press[1]) ev_dir = DIR_DOWN;
        else if (dir_press[2]) ev_dir = DIR_LEFT;
        else if (dir_press[3]) ev_dir = DIR_RIGHT;
    end

    // Decide push/pop/drop; restart suppresses everything, a full queue still accepts with a pop.
    always_comb begin
`ifdef SNAKE_REVERSE_FILTER_EN
        rev = (ev_dir == dir_opposite(ref_dir));
`else
        rev = 1'b0;
`endif
        ev_ok     = (ev_dir != DIR_NONE) && (ev_dir != ref_dir) && !rev;
        pop       = tick && !empty && !rst_db;
        push      = ev_ok && (!full || pop) && !rst_db;
        drop_full = ev_ok && full && !pop && !rst_db;
    end

    // Queue pointers, current heading and overflow pulse; restart flushes and parks at DIR_START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dir_q    <= DIR_START;
            overflow <= 1'b0;
        end else if (rst_db) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            dir_q    <= DIR_START;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dir_q  <= mem[rd_ptr[AW-1:0]];
            end
            overflow <= drop_full;
        end
    end

    // Queue storage; a full-queue push overwrites the slot being popped, which reads its old value.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= ev_dir;
    end

    assign direction  = rst_db ? DIR_RESET : dir_q;
    assign game_reset = rst_db;
    assign q_level    = level;

endmodule

// File: tb/tb_snake_dir_queue_ctrl.sv
// Bench for snake_dir_queue_ctrl: directed scenarios plus random button/tick traffic,
// all compared each cycle against a queue-based behavioural model.
module tb_snake_dir_queue_ctrl;

    localparam int DEB   = 4;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_dir_n = 4'hF;
    logic       btn_restart = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] direction;
    logic       game_reset;
    logic [2:0] q_level;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int raw_pipe [5][$];
    int seen     [5][$];
    bit db       [5];
    bit ev       [4];
    int mq [$];
    int mdir;
    bit movf;

    always #5 clk = ~clk;

    snake_dir_queue_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC),
        .QUEUE_DEPTH    (DEPTH),
        .DIR_START      (3'b100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_dir_n  (btn_dir_n),
        .btn_restart(btn_restart),
        .tick       (tick),
        .direction  (direction),
        .game_reset (game_reset),
        .q_level    (q_level),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

`ifdef SNAKE_REVERSE_FILTER_EN
    function automatic int opp(input int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction
`endif

    task model_reset();
        for (int b = 0; b < 5; b++) begin
            raw_pipe[b].delete();
            for (int k = 0; k < SYNC; k++) raw_pipe[b].push_back(0);
            seen[b].delete();
            db[b] = 1'b0;
        end
        for (int i = 0; i < 4; i++) ev[i] = 1'b0;
        mq.delete();
        mdir = 4;
        movf = 1'b0;
    endtask

    task model_edge();
        int  evd, refd, lvl, s;
        bit  pop, push, rev, allsame, newev;
        movf = 1'b0;
        push = 1'b0;
        if (db[4]) begin
            mq.delete();
            mdir = 4;
        end else begin
            evd = 0;
            for (int i = 3; i >= 0; i--) if (ev[i]) evd = i + 1;
            pop = tick && (mq.size() > 0);
            if (evd != 0) begin
                refd = (mq.size() > 0) ? mq[$] : mdir;
                rev  = 1'b0;
`ifdef SNAKE_REVERSE_FILTER_EN
                rev  = (evd == opp(refd));
`endif
                if (evd != refd && !rev) begin
                    if (mq.size() < DEPTH || pop) push = 1'b1;
                    else movf = 1'b1;
                end
            end
            if (pop)  mdir = mq.pop_front();
            if (push) mq.push_back(evd);
        end
        for (int b = 0; b < 5; b++) begin
            lvl = (b < 4) ? int'(!btn_dir_n[b]) : int'(btn_restart);
            raw_pipe[b].push_back(lvl);
            s = raw_pipe[b].pop_front();
            seen[b].push_back(s);
            if (seen[b].size() > DEB) void'(seen[b].pop_front());
            newev = 1'b0;
            if (seen[b].size() == DEB && s != int'(db[b])) begin
                allsame = 1'b1;
                foreach (seen[b][k]) if (seen[b][k] != s) allsame = 1'b0;
                if (allsame) begin
                    db[b] = (s != 0);
                    newev = (s != 0);
                end
            end
            if (b < 4) ev[b] = newev;
        end
    endtask

    task step();
        @(posedge clk);
        model_edge();
        #1;
        chk("direction", direction, db[4] ? 7 : mdir);
        chk("game_reset", game_reset, db[4]);
        chk("q_level", q_level, mq.size());
        chk("overflow", overflow, movf);
    endtask

    // Hold a direction button long enough to be queued; optionally tick on the push cycle.
    task press_hold(input int b, input bit tk);
        btn_dir_n[b] = 1'b0;
        repeat (6) step();
        tick = tk;
        step();
        tick = 1'b0;
    endtask

    task release_btn(input int b);
        btn_dir_n[b] = 1'b1;
        repeat (8) step();
    endtask

    task do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        int t3_exp [4];
        t3_exp = '{3, 1, 4, 2};
        model_reset();

        // reset values
        #12;
        chk("rst_direction", direction, 4);
        chk("rst_game_reset", game_reset, 0);
        chk("rst_q_level", q_level, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // 1: short glitch on LEFT
        btn_dir_n[2] = 1'b0;
        repeat (3) step();
        btn_dir_n[2] = 1'b1;
        repeat (8) step();
        chk("glitch_q_level", q_level, 0);

        // 2: UP held 10 cycles, queued on cycle 7
        btn_dir_n[0] = 1'b0;
        repeat (6) step();
        chk("latency_q_before", q_level, 0);
        step();
        chk("latency_q_at7", q_level, 1);
        repeat (3) step();
        btn_dir_n[0] = 1'b1;
        do_tick();
        chk("tick_dir_up", direction, 1);
        chk("tick_q_empty", q_level, 0);
        repeat (8) step();

        // back to RIGHT
        press_hold(3, 1'b0);
        release_btn(3);
        do_tick();
        chk("dir_right", direction, 4);

        // 3: fill queue, overflow on the fifth press, then drain
        press_hold(2, 1'b0); release_btn(2);
        press_hold(0, 1'b0); release_btn(0);
        press_hold(3, 1'b0); release_btn(3);
        press_hold(1, 1'b0); release_btn(1);
        chk("full_q_level", q_level, 4);
        press_hold(2, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_q_level", q_level, 4);
        release_btn(2);
        chk("ovf_pulse_gone", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            chk("drain_dir", direction, t3_exp[i]);
        end
        chk("drain_q_empty", q_level, 0);

        // 4: DOWN queued, UP push coincides with tick
        press_hold(3, 1'b0); release_btn(3);
        do_tick();
        chk("t4_dir_right", direction, 4);
        press_hold(1, 1'b0); release_btn(1);
        chk("t4_q_down", q_level, 1);
        press_hold(0, 1'b1);
`ifdef SNAKE_REVERSE_FILTER_EN
        chk("t4_q_filtered", q_level, 0);
`else
        chk("t4_q_unchanged", q_level, 1);
`endif
        chk("t4_dir_down", direction, 2);
        chk("t4_no_ovf", overflow, 0);
        release_btn(0);

        // 5: restart with three entries queued
        do_tick();
        chk("t5_q_empty", q_level, 0);
        press_hold(2, 1'b0); release_btn(2);
        press_hold(0, 1'b0); release_btn(0);
        press_hold(3, 1'b0); release_btn(3);
        chk("t5_q_three", q_level, 3);
        btn_restart = 1'b1;
        repeat (5) step();
        chk("t5_not_yet", game_reset, 0);
        step();
        chk("t5_game_reset", game_reset, 1);
        chk("t5_dir_reset", direction, 7);
        btn_restart = 1'b0;
        step();
        chk("t5_flushed", q_level, 0);
        repeat (4) step();
        chk("t5_still_reset", game_reset, 1);
        step();
        chk("t5_released", game_reset, 0);
        chk("t5_dir_start", direction, 4);

        // 6: async reset mid-debounce with the queue non-empty
        press_hold(2, 1'b0); release_btn(2);
        chk("t6_q_one", q_level, 1);
        btn_dir_n[0] = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_dir", direction, 4);
        chk("t6_async_q", q_level, 0);
        chk("t6_async_ovf", overflow, 0);
        chk("t6_async_gr", game_reset, 0);
        model_reset();
        btn_dir_n = 4'hF;
        #2;
        rst_n = 1'b1;
        repeat (10) step();
        chk("t6_no_stale_press", q_level, 0);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) btn_dir_n[b] = ~btn_dir_n[b];
            if ($urandom_range(0, 59) == 0) btn_restart = ~btn_restart;
            tick = ($urandom_range(0, 3) == 0);
            step();
        end
        tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
